loop_txn_profiler: RTL and testbench

Synthesizable per-invocation profiler for one pipelined HLS loop; it sits directly upstream of upc_loop_monitor in the cosim harness.
- Input probes are the same taps the upc loop interface uses: ap_CS_fsm, stage block and enable signals, and loop start/ready/done.
- It condenses each loop invocation into one fixed-format record: latency, iterations, stalls and peak occupancy.
- Records are pushed through a small FIFO with a valid/ready handshake to the monitor/CSV dump side.

---
 rtl/loop_prof_pkg.sv | 71 +++++++
 rtl/prof_rec_fifo.sv | 61 ++++++
 rtl/loop_txn_profiler.sv | 124 ++++++++++++
 tb/tb_loop_txn_profiler.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loop_prof_pkg.sv
// Shared types and helpers for the loop transaction profiler.
//   prof_state_e : profiler FSM states (IDLE, RUN)
//   prof_rec_t   : one closed-invocation record, MSB first
//                  {txn_id, lat, it_start, it_end, stall, max_inflight, partial}
//   prof_acc_t   : running per-invocation accumulators
//   rec_w()      : packed record width for a given counter width
//   sat_inc()    : saturating +1 for counter-width values
//   acc_step()   : one cycle of accumulator update for a set of events
package loop_prof_pkg;

    localparam int PROF_CNT_W = 32;
    localparam int TXN_W      = 16;
    localparam int OCC_W      = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } prof_state_e;

    typedef logic [PROF_CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [TXN_W-1:0] txn_id;
        cnt_t             lat;
        cnt_t             it_start;
        cnt_t             it_end;
        cnt_t             stall;
        logic [OCC_W-1:0] max_inflight;
        logic             partial;
    } prof_rec_t;

    typedef struct packed {
        cnt_t             lat;
        cnt_t             it_start;
        cnt_t             it_end;
        cnt_t             stall;
        cnt_t             inflight;
        logic [OCC_W-1:0] max_inflight;
    } prof_acc_t;

    function automatic int rec_w(input int cnt_w);
        return TXN_W + 4 * cnt_w + OCC_W + 1;
    endfunction

    function automatic cnt_t sat_inc(input cnt_t v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Applies one RUN cycle's events. Inflight is unchanged when both ends
    // fire and never drops below zero; the peak is taken after the update.
    function automatic prof_acc_t acc_step(input prof_acc_t a,
                                           input logic s_fire,
                                           input logic e_fire,
                                           input logic stall_ev);
        prof_acc_t        n;
        logic [OCC_W-1:0] occ;
        n     = a;
        n.lat = sat_inc(a.lat);
        if (s_fire)   n.it_start = sat_inc(a.it_start);
        if (e_fire)   n.it_end   = sat_inc(a.it_end);
        if (stall_ev) n.stall    = sat_inc(a.stall);
        if (s_fire && !e_fire)
            n.inflight = sat_inc(a.inflight);
        else if (e_fire && !s_fire && a.inflight != '0)
            n.inflight = a.inflight - 1'b1;
        occ = (|n.inflight[PROF_CNT_W-1:OCC_W]) ? '1 : n.inflight[OCC_W-1:0];
        if (occ > a.max_inflight) n.max_inflight = occ;
        return n;
    endfunction

endpackage

// File: rtl/prof_rec_fifo.sv
// Synchronous record FIFO with registered storage.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and record; accepted when not full, or when
//                full and a pop happens in the same cycle
//   pop        : read request; ignored while empty
//   dout       : head record (zero while empty)
//   full/empty : occupancy flags
module prof_rec_fifo
    import loop_prof_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  prof_rec_t din,
    input  logic      pop,
    output prof_rec_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    prof_rec_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop & ~empty;
    // When full, the slot being popped is the one being written.
    assign wr_en = push & (~full | rd_en);
    assign dout  = empty ? '0 : mem[rd_ptr];

    // NOTE: storage is deliberately not reset; count gates dout, so stale
    // entries are never visible and the array maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/loop_txn_profiler.sv
// Per-invocation profiler for one pipelined HLS loop. Each invocation is
// condensed into one prof_rec_t and queued towards the monitor.
//   ap_clk, ap_rst_n         : clock, asynchronous active-low reset
//   cur_state                : loop FSM state (ap_CS_fsm)
//   iter_{start,end}_state   : states in which an iteration starts / ends
//   iter_{start,end}_block   : subdone block of the start / end stage
//   iter_{start,end}_enable  : ap_enable_reg of first / last pipeline iteration
//   loop_start, loop_done    : ap_start / ap_done_int of the loop module
//   finish                   : end-of-simulation request (closes a partial record)
//   rec_valid/ready/data     : record stream, valid/ready handshake
//   drop_cnt                 : records lost to a full FIFO (saturating)
//   err_underflow            : sticky, an iteration ended with nothing in flight
// CNT_W must equal PROF_CNT_W, which fixes the record layout.
module loop_txn_profiler
    import loop_prof_pkg::*;
#(
    parameter  int STATE_W    = 32,
    parameter  int CNT_W      = PROF_CNT_W,
    parameter  int FIFO_DEPTH = 4,
    localparam int REC_W      = rec_w(CNT_W)
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic               iter_start_block,
    input  logic               iter_end_block,
    input  logic               iter_start_enable,
    input  logic               iter_end_enable,
    input  logic               loop_start,
    input  logic               loop_done,
    input  logic               finish,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [REC_W-1:0]   rec_data,
    output logic [15:0]        drop_cnt,
    output logic               err_underflow
);

    prof_state_e      state, state_nxt;
    prof_acc_t        acc, acc_nxt, acc_base, acc_upd, acc_fresh;
    prof_rec_t        rec_close, fifo_dout;
    logic [TXN_W-1:0] txn_id;
    logic             s_fire, e_fire, stall_ev;
    logic             run_eff, close, reopen, underflow;
    logic             fifo_full, fifo_empty, pop;

    assign s_fire   = (cur_state == iter_start_state) & iter_start_enable & ~iter_start_block;
    assign e_fire   = (cur_state == iter_end_state)   & iter_end_enable   & ~iter_end_block;
    assign stall_ev = (cur_state == iter_start_state) & iter_start_enable &  iter_start_block;

    // A start seen in IDLE makes this cycle latency cycle 1, so it behaves as
    // a RUN cycle; a start while already in RUN changes nothing here.
    assign run_eff = (state == RUN) | loop_start;
    assign close   = run_eff & (loop_done | finish);
    assign reopen  = close & loop_done & loop_start;

    // Entry from IDLE counts from zero; stale accumulators are never reused.
    assign acc_base  = (state == RUN) ? acc : '0;
    assign acc_upd   = acc_step(acc_base, s_fire, e_fire, stall_ev);
    assign acc_fresh = acc_step('0, s_fire, e_fire, stall_ev);
    assign underflow = run_eff & e_fire & ~s_fire & (acc_base.inflight == '0);

    assign rec_close = '{txn_id:       txn_id,
                         lat:          acc_upd.lat,
                         it_start:     acc_upd.it_start,
                         it_end:       acc_upd.it_end,
                         stall:        acc_upd.stall,
                         max_inflight: acc_upd.max_inflight,
                         partial:      finish & ~loop_done};

    // NOTE: defaults first so every path assigns both outputs; no latches.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        if (close)        state_nxt = reopen ? RUN : IDLE;
        else if (run_eff) state_nxt = RUN;
        // Done+start: the closing record took acc_upd; the new invocation
        // starts from this cycle's events alone.
        if (reopen)       acc_nxt = acc_fresh;
        else if (run_eff) acc_nxt = acc_upd;
    end

    // NOTE: non-blocking assignments for all registered state so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc           <= '0;
            txn_id        <= '0;
            err_underflow <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            acc <= acc_nxt;
            if (close)     txn_id        <= txn_id + 1'b1;
            if (underflow) err_underflow <= 1'b1;
            if (close && fifo_full && !pop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign rec_valid = ~fifo_empty;
    assign pop       = rec_valid & rec_ready;
    assign rec_data  = fifo_dout;

    prof_rec_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .push  (close),
        .din   (rec_close),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_loop_txn_profiler.sv
// Self-checking bench for loop_txn_profiler: a transaction-level model of
// invocations and the record queue is compared against the DUT on every
// falling edge; directed scenarios additionally pin record fields to
// hand-computed literals; a random phase exercises arbitrary event mixes.
module tb_loop_txn_profiler;

    localparam int STATE_W = 32;
    localparam int CNT_W   = 32;
    localparam int DEPTH   = 4;
    localparam int REC_W   = 16 + 4 * CNT_W + 9;
    localparam longint CMAX = 64'd4294967295;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n = 1'b0;
    logic [STATE_W-1:0] cur_state = 32'd0;
    logic [STATE_W-1:0] iter_start_state = 32'd2;
    logic [STATE_W-1:0] iter_end_state = 32'd2;
    logic               iter_start_block = 1'b0;
    logic               iter_end_block = 1'b0;
    logic               iter_start_enable = 1'b0;
    logic               iter_end_enable = 1'b0;
    logic               loop_start = 1'b0;
    logic               loop_done = 1'b0;
    logic               finish = 1'b0;
    logic               rec_valid;
    logic               rec_ready = 1'b1;
    logic [REC_W-1:0]   rec_data;
    logic [15:0]        drop_cnt;
    logic               err_underflow;

    int n_checks = 0;
    int n_errors = 0;
    int ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

    loop_txn_profiler #(
        .STATE_W    (STATE_W),
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .ap_clk            (ap_clk),
        .ap_rst_n          (ap_rst_n),
        .cur_state         (cur_state),
        .iter_start_state  (iter_start_state),
        .iter_end_state    (iter_end_state),
        .iter_start_block  (iter_start_block),
        .iter_end_block    (iter_end_block),
        .iter_start_enable (iter_start_enable),
        .iter_end_enable   (iter_end_enable),
        .loop_start        (loop_start),
        .loop_done         (loop_done),
        .finish            (finish),
        .rec_valid         (rec_valid),
        .rec_ready         (rec_ready),
        .rec_data          (rec_data),
        .drop_cnt          (drop_cnt),
        .err_underflow     (err_underflow)
    );

    initial forever #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        longint lat, its, ite, stl;
        int     infl, mx;
    } acc_t;

    acc_t             m_acc;
    bit               m_run = 1'b0;
    int               m_txn = 0;
    int               m_drop = 0;
    bit               m_err = 1'b0;
    logic [REC_W-1:0] m_q[$];
    logic [REC_W-1:0] seen[$];

    function automatic longint sat(input longint v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic acc_t apply(input acc_t a, input bit sf, input bit ef, input bit st);
        acc_t n = a;
        n.lat = sat(a.lat + 1);
        if (sf) n.its = sat(a.its + 1);
        if (ef) n.ite = sat(a.ite + 1);
        if (st) n.stl = sat(a.stl + 1);
        if (sf && !ef) n.infl = a.infl + 1;
        else if (ef && !sf && a.infl > 0) n.infl = a.infl - 1;
        if (((n.infl > 255) ? 255 : n.infl) > n.mx) n.mx = (n.infl > 255) ? 255 : n.infl;
        return n;
    endfunction

    function automatic acc_t empty_acc();
        acc_t z;
        z.lat = 0; z.its = 0; z.ite = 0; z.stl = 0; z.infl = 0; z.mx = 0;
        return z;
    endfunction

    always @(posedge ap_clk or negedge ap_rst_n) begin
        bit sf, ef, st, pop, cls;
        logic [15:0]      tid;
        logic [31:0]      f_lat, f_its, f_ite, f_stl;
        logic [7:0]       f_mx;
        logic [REC_W-1:0] rec;
        if (!ap_rst_n) begin
            m_run = 0; m_txn = 0; m_drop = 0; m_err = 0;
            m_q.delete();
        end else begin
            sf  = (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
            ef  = (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
            st  = (cur_state == iter_start_state) && iter_start_enable && iter_start_block;
            pop = (m_q.size() > 0) && rec_ready;
            cls = 0;
            rec = '0;
            if (!m_run && loop_start) begin
                m_run = 1;
                m_acc = empty_acc();
            end
            if (m_run) begin
                if (ef && !sf && m_acc.infl == 0) m_err = 1;
                m_acc = apply(m_acc, sf, ef, st);
                if (loop_done || finish) begin
                    tid = 16'(m_txn); f_lat = 32'(m_acc.lat); f_its = 32'(m_acc.its);
                    f_ite = 32'(m_acc.ite); f_stl = 32'(m_acc.stl); f_mx = 8'(m_acc.mx);
                    rec = {tid, f_lat, f_its, f_ite, f_stl, f_mx, (finish && !loop_done)};
                    cls = 1;
                    m_txn = (m_txn + 1) % 65536;
                    m_run = 0;
                    if (loop_done && loop_start) begin
                        m_run = 1;
                        m_acc = apply(empty_acc(), sf, ef, st);
                    end
                end
            end
            if (pop) void'(m_q.pop_front());
            if (cls) begin
                if (m_q.size() < DEPTH) m_q.push_back(rec);
                else if (m_drop < 65535) m_drop++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge ap_clk) begin
        check("rec_valid", 160'(rec_valid), 160'(m_q.size() > 0));
        if (m_q.size() > 0) check("rec_data", 160'(rec_data), 160'(m_q[0]));
        check("drop_cnt", 160'(drop_cnt), 160'(m_drop));
        check("err_underflow", 160'(err_underflow), 160'(m_err));
        if (rec_valid && rec_ready) seen.push_back(rec_data);
    end

    initial forever begin
        @(posedge ap_clk); #1;
        case (ready_mode)
            0:       rec_ready = 1'b0;
            1:       rec_ready = 1'b1;
            default: rec_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- record field helpers ----------------
    function automatic int f_txn(input logic [REC_W-1:0] r); return int'(r[152:137]); endfunction
    function automatic int f_lat(input logic [REC_W-1:0] r); return int'(r[136:105]); endfunction
    function automatic int f_its(input logic [REC_W-1:0] r); return int'(r[104:73]);  endfunction
    function automatic int f_ite(input logic [REC_W-1:0] r); return int'(r[72:41]);   endfunction
    function automatic int f_stl(input logic [REC_W-1:0] r); return int'(r[40:9]);    endfunction
    function automatic int f_mx (input logic [REC_W-1:0] r); return int'(r[8:1]);     endfunction

    // ---------------- stimulus ----------------
    task automatic drive_idle();
        cur_state = 32'd0;
        iter_start_enable = 0; iter_end_enable = 0;
        iter_start_block = 0;  iter_end_block = 0;
        loop_start = 0; loop_done = 0; finish = 0;
    endtask

    task automatic idle(input int n);
        drive_idle();
        repeat (n) begin @(posedge ap_clk); #1; end
    endtask

    task automatic do_reset();
        drive_idle();
        ap_rst_n = 0;
        repeat (2) @(negedge ap_clk);
        check("rst_rec_valid", 160'(rec_valid), 160'(0));
        check("rst_rec_data", 160'(rec_data), 160'(0));
        check("rst_drop_cnt", 160'(drop_cnt), 160'(0));
        check("rst_err", 160'(err_underflow), 160'(0));
        @(posedge ap_clk); #1;
        ap_rst_n = 1;
        idle(1);
        seen.delete();
    endtask

    // One pipelined invocation at II=1: issues from cycle k0, each iteration
    // retires `depth` cycles after issue, done the cycle after the last
    // retire. Optional stall window, early finish, and chaining of the next
    // start onto the done cycle.
    task automatic run_txn(input int n, input int depth, input int stall_k, input int stall_len,
                           input int fin_after, input bit pre_started, input bit chain, input int k0);
        int       issued = 0;
        int       k = pre_started ? 1 : 0;
        int       stall_left = stall_len;
        bit       done_now = 0;
        bit       s;
        bit [7:0] pipe = 8'd0;
        bit [7:0] mask = (8'd1 << depth) - 8'd1;
        while (!done_now && k < 500) begin
            drive_idle();
            cur_state  = 32'd2;
            loop_start = (k == 0);
            if (fin_after >= 0 && issued == fin_after) begin
                finish = 1; done_now = 1;
            end else if (issued == n && pipe == 0) begin
                loop_done = 1; loop_start = chain; done_now = 1;
            end else if (k == stall_k && stall_left > 0) begin
                iter_start_enable = (issued < n) && (k >= k0);
                iter_end_enable   = pipe[depth-1];
                iter_start_block  = 1; iter_end_block = 1;
                stall_left--; stall_k++;
            end else begin
                s = (issued < n) && (k >= k0);
                iter_start_enable = s;
                iter_end_enable   = pipe[depth-1];
                pipe = ((pipe << 1) | 8'(s)) & mask;
                issued += int'(s);
            end
            @(posedge ap_clk); #1;
            k++;
        end
        if (!done_now) check("txn_bound", 160'(0), 160'(1));
        if (!chain) drive_idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        do_reset();

        // Basic: 10 iterations, II=1, depth 2.
        run_txn(10, 2, -1, 0, -1, 0, 0, 0);
        idle(3);
        check("basic_count", 160'(seen.size()), 160'(1));
        if (seen.size() > 0) begin
            check("basic_txn", 160'(f_txn(seen[0])), 160'(0));
            check("basic_lat", 160'(f_lat(seen[0])), 160'(13));
            check("basic_its", 160'(f_its(seen[0])), 160'(10));
            check("basic_ite", 160'(f_ite(seen[0])), 160'(10));
            check("basic_stall", 160'(f_stl(seen[0])), 160'(0));
            check("basic_max", 160'(f_mx(seen[0])), 160'(2));
            check("basic_partial", 160'(seen[0][0]), 160'(0));
        end

        // Stall window of 3 cycles mid-loop.
        do_reset();
        run_txn(10, 2, 5, 3, -1, 0, 0, 0);
        idle(3);
        check("stall_count", 160'(seen.size()), 160'(1));
        if (seen.size() > 0) begin
            check("stall_lat", 160'(f_lat(seen[0])), 160'(16));
            check("stall_stall", 160'(f_stl(seen[0])), 160'(3));
            check("stall_its", 160'(f_its(seen[0])), 160'(10));
        end

        // Back-to-back: done and start together.
        do_reset();
        run_txn(10, 2, -1, 0, -1, 0, 1, 0);
        run_txn(10, 2, -1, 0, -1, 1, 0, 0);
        idle(3);
        check("b2b_count", 160'(seen.size()), 160'(2));
        if (seen.size() > 1) begin
            check("b2b_txn0", 160'(f_txn(seen[0])), 160'(0));
            check("b2b_lat0", 160'(f_lat(seen[0])), 160'(13));
            check("b2b_txn1", 160'(f_txn(seen[1])), 160'(1));
            check("b2b_lat1", 160'(f_lat(seen[1])), 160'(14));
        end

        // Finish while running.
        do_reset();
        run_txn(10, 2, -1, 0, 5, 0, 0, 0);
        idle(3);
        check("fin_count", 160'(seen.size()), 160'(1));
        if (seen.size() > 0) begin
            check("fin_partial", 160'(seen[0][0]), 160'(1));
            check("fin_its", 160'(f_its(seen[0])), 160'(5));
            check("fin_lat", 160'(f_lat(seen[0])), 160'(6));
        end

        // Backpressure: 6 invocations with the consumer stalled.
        ready_mode = 0;
        do_reset();
        repeat (6) begin
            run_txn(2, 1, -1, 0, -1, 0, 0, 0);
            idle(2);
        end
        @(negedge ap_clk);
        check("bp_drop", 160'(drop_cnt), 160'(2));
        check("bp_valid", 160'(rec_valid), 160'(1));
        @(posedge ap_clk); #1;
        seen.delete();
        ready_mode = 1;
        idle(8);
        check("bp_drain_count", 160'(seen.size()), 160'(4));
        for (int i = 0; i < 4 && i < seen.size(); i++)
            check("bp_drain_txn", 160'(f_txn(seen[i])), 160'(i));

        // Underflow: an end with nothing in flight, then a normal iteration.
        do_reset();
        drive_idle(); cur_state = 32'd2; loop_start = 1;
        @(posedge ap_clk); #1;
        drive_idle(); cur_state = 32'd2; iter_end_enable = 1;
        @(posedge ap_clk); #1;
        drive_idle(); cur_state = 32'd2; iter_start_enable = 1;
        @(posedge ap_clk); #1;
        drive_idle(); loop_done = 1;
        @(posedge ap_clk); #1;
        idle(3);
        check("uf_err", 160'(err_underflow), 160'(1));
        check("uf_count", 160'(seen.size()), 160'(1));
        if (seen.size() > 0) begin
            check("uf_max", 160'(f_mx(seen[0])), 160'(1));
            check("uf_ite", 160'(f_ite(seen[0])), 160'(1));
            check("uf_lat", 160'(f_lat(seen[0])), 160'(4));
        end

        // Reset mid-RUN discards the open invocation.
        drive_idle(); cur_state = 32'd2; loop_start = 1; iter_start_enable = 1;
        @(posedge ap_clk); #1;
        drive_idle(); cur_state = 32'd2; iter_start_enable = 1;
        @(posedge ap_clk); #1;
        do_reset();
        drive_idle(); loop_done = 1;
        @(posedge ap_clk); #1;
        idle(4);
        check("rst_mid_valid", 160'(rec_valid), 160'(0));
        check("rst_mid_count", 160'(seen.size()), 160'(0));

        // Random phase: arbitrary event mixes with random backpressure.
        do_reset();
        iter_end_state = 32'd3;
        ready_mode = 2;
        for (int c = 0; c < 4000; c++) begin
            cur_state = ($urandom_range(0, 3) == 0) ? 32'd5 :
                        ($urandom_range(0, 1) == 1) ? 32'd2 : 32'd3;
            iter_start_enable = ($urandom_range(0, 3) != 0);
            iter_end_enable   = ($urandom_range(0, 3) != 0);
            iter_start_block  = ($urandom_range(0, 3) == 0);
            iter_end_block    = ($urandom_range(0, 3) == 0);
            loop_start        = ($urandom_range(0, 9) == 0);
            loop_done         = ($urandom_range(0, 11) == 0);
            finish            = ($urandom_range(0, 39) == 0);
            @(posedge ap_clk); #1;
        end
        ready_mode = 1;
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
